// File: rtl/mem_dump_sequencer_if.sv
// rtl/mem_dump_sequencer_if.sv - control, memory and shift-register handshake bundle for the dump sequencer
interface mem_dump_sequencer_if;
    logic       start;
    logic [7:0] start_addr;
    logic [7:0] count;
    logic       abort;
    logic       tx_done;
    logic [7:0] addr;
    logic       access_mem;
    logic       rw_mem;
    logic       parallel_load;
    logic       start_tx;
    logic       busy;
    logic       done;
    logic       err;
    logic [8:0] sent_cnt;

    modport master (
        output start, start_addr, count, abort, tx_done,
        input  addr, access_mem, rw_mem, parallel_load, start_tx,
               busy, done, err, sent_cnt
    );

    modport slave (
        input  start, start_addr, count, abort, tx_done,
        output addr, access_mem, rw_mem, parallel_load, start_tx,
               busy, done, err, sent_cnt
    );
endinterface

// File: rtl/mem_dump_sequencer.sv
// rtl/mem_dump_sequencer.sv - reads a burst of memory words and hands each one to a serial transmitter
module mem_dump_sequencer #(
    parameter int TX_TIMEOUT = 1024,
    parameter int MEM_RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_dump_sequencer_if.slave   bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_LOAD = 3'd3;
    localparam logic [2:0] S_TX   = 3'd4;
    localparam logic [2:0] S_NEXT = 3'd5;
    localparam logic [2:0] S_FIN  = 3'd6;

    localparam int TMO_W = $clog2(TX_TIMEOUT + 1);
    localparam int LAT_W = $clog2(MEM_RD_LAT + 1) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TX_TIMEOUT - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_RD_LAT - 1);

    logic [2:0]       state;
    logic [7:0]       addr_q;
    logic [8:0]       rem_q;
    logic [8:0]       sent_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic             err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            addr_q  <= 8'd0;
            rem_q   <= 9'd0;
            sent_q  <= 9'd0;
            tmo_cnt <= '0;
            lat_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            // Abort wins over every other transition, including a TX_DONE in the same cycle.
            if (state != S_IDLE && bus.abort) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            addr_q <= bus.start_addr;
                            rem_q  <= (bus.count == 8'd0) ? 9'd256 : {1'b0, bus.count};
                            sent_q <= 9'd0;
                            state  <= S_READ;
                        end
                    end
                    S_READ: begin
                        lat_cnt <= '0;
                        state   <= (MEM_RD_LAT == 0) ? S_LOAD : S_WAIT;
                    end
                    S_WAIT: begin
                        if (lat_cnt == LAT_LAST) begin
                            state <= S_LOAD;
                        end else begin
                            lat_cnt <= lat_cnt + 1'b1;
                        end
                    end
                    S_LOAD: begin
                        tmo_cnt <= '0;
                        state   <= S_TX;
                    end
                    S_TX: begin
                        // TX_DONE in the expiring cycle still completes the word.
                        if (bus.tx_done) begin
                            state <= S_NEXT;
                        end else if (tmo_cnt == TMO_LAST) begin
                            err_q <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    S_NEXT: begin
                        addr_q <= addr_q + 8'd1;
                        sent_q <= sent_q + 9'd1;
                        rem_q  <= rem_q - 9'd1;
                        state  <= (rem_q == 9'd1) ? S_FIN : S_READ;
                    end
                    S_FIN: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.addr          = addr_q;
    assign bus.access_mem    = (state == S_READ);
    assign bus.rw_mem        = 1'b0;
    assign bus.parallel_load = (state == S_LOAD);
    assign bus.start_tx      = (state == S_TX);
    assign bus.busy          = (state != S_IDLE);
    assign bus.done          = (state == S_FIN);
    assign bus.err           = err_q;
    assign bus.sent_cnt      = sent_q;

endmodule

// File: tb/tb_mem_dump_sequencer.sv
// tb/tb_mem_dump_sequencer.sv - scoreboard bench for mem_dump_sequencer
module tb_mem_dump_sequencer;
    localparam int LAT = 2;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_err = 0;
    int   n_done = 0;
    logic [7:0] exp_addr[$];

    mem_dump_sequencer_if bus();

    mem_dump_sequencer #(.TX_TIMEOUT(TMO), .MEM_RD_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every read strobe must match the next address the stimulus queued.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.access_mem) begin
                if (exp_addr.size() == 0) check_eq("read_unexpected", {24'd0, bus.addr}, 32'hFFFF_FFFF);
                else check_eq("read_addr", {24'd0, bus.addr}, {24'd0, exp_addr.pop_front()});
                check_eq("rw_mem", bus.rw_mem, 0);
            end
            check_eq("strobe_excl", ($countones({bus.access_mem, bus.parallel_load, bus.start_tx}) <= 1), 1);
            check_eq("done_err_excl", bus.done & bus.err, 0);
            if (bus.err) n_err++;
            if (bus.done) n_done++;
        end
    end

    function automatic logic [31:0] out_vec();
        return {8'd0, bus.addr, bus.access_mem, bus.rw_mem, bus.parallel_load,
                bus.start_tx, bus.busy, bus.done, bus.err, bus.sent_cnt};
    endfunction

    task automatic start_burst(input logic [7:0] a, input logic [7:0] c);
        bus.start_addr = a;
        bus.count      = c;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    task automatic wait_tx();
        for (int i = 0; i < 50 && !bus.start_tx; i++) @(negedge clk);
        check_eq("tx_seen", bus.start_tx, 1);
    endtask

    task automatic serve_word(input int delay);
        wait_tx();
        repeat (delay - 1) @(negedge clk);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
    endtask

    task automatic run_burst(input logic [7:0] a, input logic [7:0] c, input int delay);
        int   n;
        int   errs0;
        int   dones0;
        logic [7:0] fin_addr;
        n = (c == 8'd0) ? 256 : int'(c);
        errs0 = n_err;
        dones0 = n_done;
        for (int k = 0; k < n; k++) exp_addr.push_back(8'(int'(a) + k));
        fin_addr = 8'(int'(a) + n);
        start_burst(a, c);
        for (int k = 0; k < n; k++) serve_word(delay);
        for (int i = 0; i < 20 && !bus.done; i++) @(negedge clk);
        check_eq("done_seen", bus.done, 1);
        check_eq("sent_cnt", {23'd0, bus.sent_cnt}, n);
        check_eq("end_addr", {24'd0, bus.addr}, {24'd0, fin_addr});
        @(negedge clk);
        check_eq("idle_after_fin", {bus.busy, bus.done}, 2'b00);
        check_eq("reads_consumed", exp_addr.size(), 0);
        check_eq("no_err_in_burst", n_err - errs0, 0);
        check_eq("one_done_pulse", n_done - dones0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.start_addr = 8'd0; bus.count = 8'd0;
        bus.abort = 1'b0; bus.tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", out_vec(), 0);
        reset = 1'b0;
        @(negedge clk);

        // Single word with cycle-exact latency checks
        exp_addr.push_back(8'h10);
        start_burst(8'h10, 8'd1);
        check_eq("busy_n1", bus.busy, 1);
        check_eq("access_n1", bus.access_mem, 1);
        repeat (LAT) @(negedge clk);
        check_eq("no_load_early", bus.parallel_load, 0);
        @(negedge clk);
        check_eq("load_n2lat", bus.parallel_load, 1);
        @(negedge clk);
        check_eq("tx_n3lat", bus.start_tx, 1);
        repeat (4) @(negedge clk);
        check_eq("tx_held", bus.start_tx, 1);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        check_eq("next_no_tx", {bus.start_tx, bus.done}, 2'b00);
        @(negedge clk);
        check_eq("done_single", bus.done, 1);
        check_eq("sent_single", {23'd0, bus.sent_cnt}, 1);
        check_eq("addr_single", {24'd0, bus.addr}, 32'h11);
        @(negedge clk);
        check_eq("idle_single", bus.busy, 0);

        // Wrap and full 256-word burst
        run_burst(8'hFE, 8'd3, 2);
        run_burst(8'h37, 8'd0, 1);

        // Abort together with TX_DONE in word 2
        exp_addr.push_back(8'h40);
        exp_addr.push_back(8'h41);
        n_done = 0;
        start_burst(8'h40, 8'd4);
        serve_word(3);
        wait_tx();
        @(negedge clk);
        bus.abort = 1'b1;
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.tx_done = 1'b0;
        check_eq("abort_idle", {bus.busy, bus.start_tx, bus.done}, 3'b000);
        check_eq("abort_sent", {23'd0, bus.sent_cnt}, 1);
        repeat (3) @(negedge clk);
        check_eq("abort_no_done", n_done, 0);
        check_eq("abort_reads", exp_addr.size(), 0);
        run_burst(8'h80, 8'd2, 1);

        // Timeout: ERR 16 cycles after TX entry
        exp_addr.push_back(8'h20);
        n_err = 0;
        start_burst(8'h20, 8'd2);
        wait_tx();
        repeat (TMO - 1) @(negedge clk);
        check_eq("tmo_last_tx", {bus.start_tx, bus.err}, 2'b10);
        @(negedge clk);
        check_eq("tmo_err", {bus.err, bus.busy}, 2'b10);
        check_eq("tmo_sent", {23'd0, bus.sent_cnt}, 0);
        @(negedge clk);
        check_eq("tmo_err_pulse", bus.err, 0);
        check_eq("tmo_err_count", n_err, 1);
        run_burst(8'h30, 8'd1, TMO);

        // Second START while busy, then reset in WAIT
        exp_addr.push_back(8'h50);
        start_burst(8'h50, 8'd3);
        bus.start_addr = 8'h99;
        bus.count = 8'd7;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("restart_ignored", {23'd0, bus.busy, bus.addr}, {23'd0, 1'b1, 8'h50});
        reset = 1'b1;
        n_err = 0;
        n_done = 0;
        @(negedge clk);
        check_eq("midreset_outputs", out_vec(), 0);
        check_eq("midreset_no_pulse", n_err + n_done, 0);
        check_eq("midreset_reads", exp_addr.size(), 0);
        reset = 1'b0;
        run_burst(8'hC0, 8'd2, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
